// File: rtl/trace_buffer_pkg.sv
// rtl/trace_buffer_pkg.sv - shared types and constants for the retirement trace buffer
// Purpose: commit-event kind encoding, the captured record layout and its width,
//          plus the byte-enable masking rule applied at capture.
// Ports:   none (package).
package trace_buffer_pkg;

   typedef enum logic [1:0] {
      TRACE_REG   = 2'd0,
      TRACE_CSR   = 2'd1,
      TRACE_STORE = 2'd2
   } trace_kind_t;

   // Encoding 3 is reserved on the commit bus and is never captured.
   localparam logic [1:0] KIND_RESERVED = 2'd3;

   typedef struct packed {
      logic [31:0] cycle;
      trace_kind_t kind;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } trace_rec_t;

   localparam int REC_W = $bits(trace_rec_t);

   // Only stores carry meaningful byte enables; other kinds record zero.
   function automatic logic [3:0] mask_strb(input logic [1:0] kind, input logic [3:0] strb);
      return (kind == TRACE_STORE) ? strb : 4'h0;
   endfunction

endpackage

// File: rtl/trace_buffer_fifo.sv
// rtl/trace_buffer_fifo.sv - generic first-word-fall-through FIFO
// Purpose: stores records between capture and the drain stream; the head entry
//          is visible on rdata without a read strobe.
// Ports:   clock, reset (async active-low), clear (sync empty), push/wdata,
//          pop, rdata (zero while empty), full, empty, level (occupancy).
module trace_fifo #(
   parameter int data_width = 8,
   parameter int depth      = 16,
   localparam int aw        = $clog2(depth)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  push,
   input  logic                  pop,
   input  logic [data_width-1:0] wdata,
   output logic [data_width-1:0] rdata,
   output logic                  full,
   output logic                  empty,
   output logic [aw:0]           level
);

   localparam logic [aw:0] PTR_ONE = 1;

   logic [aw:0]           wr_ptr_q, wr_ptr_d;
   logic [aw:0]           rd_ptr_q, rd_ptr_d;
   logic [data_width-1:0] mem_q [depth];
   logic [data_width-1:0] mem_d [depth];
   logic                  pop_ok;
   logic                  push_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[aw] != rd_ptr_q[aw]) &&
                  (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]);
   assign level = wr_ptr_q - rd_ptr_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q[aw-1:0]];

   // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q[aw-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: rdata is forced to zero whenever the FIFO is empty.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - retirement-trace capture, timestamp and drain stage
// Purpose: timestamps commit events (reg/CSR writes, stores), buffers them in a
//          FWFT FIFO and drains them over a valid/ready stream; counts drops.
// Ports:   clock, reset (async active-low), enable, flush, in_valid/in_kind/
//          in_pc/in_addr/in_strb/in_data (commit event), out_valid/out_ready/
//          out_record (drain stream), level, overflow (sticky), drop_count.
module trace_buffer
   import trace_buffer_pkg::*;
#(
   parameter int depth     = 16,
   parameter int cnt_width = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [1:0]               in_kind,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_addr,
   input  logic [3:0]               in_strb,
   input  logic [31:0]              in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [REC_W-1:0]         out_record,
   output logic [$clog2(depth):0]   level,
   output logic                     overflow,
   output logic [cnt_width-1:0]     drop_count
);

   localparam logic [cnt_width-1:0] CNT_ONE = 1;

   logic [31:0]          cycle_q, cycle_d;
   logic                 overflow_q, overflow_d;
   logic [cnt_width-1:0] drop_count_q, drop_count_d;

   logic       cap;
   logic       pop;
   logic       push;
   logic       drop;
   logic       fifo_full;
   logic       fifo_empty;
   trace_rec_t rec_in;

   assign cap  = enable & in_valid & (in_kind != KIND_RESERVED);
   assign pop  = out_valid & out_ready;
   assign push = cap & (~fifo_full | pop);
   assign drop = cap & fifo_full & ~pop;

   always_comb begin
      rec_in.cycle = cycle_q;
      rec_in.kind  = trace_kind_t'(in_kind);
      rec_in.pc    = in_pc;
      rec_in.addr  = in_addr;
      rec_in.strb  = mask_strb(in_kind, in_strb);
      rec_in.data  = in_data;
   end

   // Flush wins over any same-cycle push/pop: the event is discarded, not counted.
   trace_fifo #(
      .data_width (REC_W),
      .depth      (depth)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .clear (flush),
      .push  (push & ~flush),
      .pop   (pop & ~flush),
      .wdata (rec_in),
      .rdata (out_record),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign out_valid  = ~fifo_empty;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

   always_comb begin
      // The timestamp free-runs and wraps; flush deliberately leaves it alone.
      cycle_d      = cycle_q + 32'd1;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      if (flush) begin
         overflow_d   = 1'b0;
         drop_count_d = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != '1) begin
            drop_count_d = drop_count_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cycle_q      <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         cycle_q      <= cycle_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

endmodule

// File: tb/tb_trace_buffer.sv
// tb/tb_trace_buffer.sv - self-checking bench for trace_buffer
module tb_trace_buffer;

   localparam int DEPTH = 16;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         enable = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic [1:0]   in_kind = 2'd0;
   logic [31:0]  in_pc = '0;
   logic [31:0]  in_addr = '0;
   logic [3:0]   in_strb = '0;
   logic [31:0]  in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [133:0] out_record;
   logic [4:0]   level;
   logic         overflow;
   logic [15:0]  drop_count;

   trace_buffer #(.depth(DEPTH), .cnt_width(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_kind    (in_kind),
      .in_pc      (in_pc),
      .in_addr    (in_addr),
      .in_strb    (in_strb),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_record (out_record),
      .level      (level),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural model: a queue of records plus counters.
   logic [133:0] mq[$];
   logic [31:0]  m_cycle = '0;
   logic         m_ovf = 1'b0;
   int           m_drop = 0;
   bit           m_cap;
   bit           m_pop;
   int           m_sz;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_cycle = '0;
         m_ovf   = 1'b0;
         m_drop  = 0;
      end else begin
         m_cap = enable && in_valid && (in_kind != 2'd3);
         if (flush) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
         end else begin
            m_sz  = mq.size();
            m_pop = (m_sz > 0) && out_ready;
            if (m_pop) void'(mq.pop_front());
            if (m_cap) begin
               if (m_sz < DEPTH || m_pop)
                  mq.push_back({m_cycle, in_kind, in_pc, in_addr,
                                (in_kind == 2'd2) ? in_strb : 4'h0, in_data});
               else begin
                  m_ovf = 1'b1;
                  if (m_drop < 65535) m_drop++;
               end
            end
         end
         m_cycle = m_cycle + 32'd1;
      end
   end

   always @(posedge clock) begin
      #2;
      check("out_valid", out_valid, mq.size() > 0);
      check("level", level, mq.size());
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drop);
      check("out_record", out_record, (mq.size() > 0) ? mq[0] : 134'd0);
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic send(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] data);
      in_valid = 1'b1;
      in_kind  = k;
      in_pc    = pc;
      in_addr  = addr;
      in_strb  = strb;
      in_data  = data;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      out_ready = 1'b1;
      repeat (n) tick();
      out_ready = 1'b0;
   endtask

   logic [133:0] r;

   initial begin
      repeat (3) tick();
      check("rst_valid", out_valid, 1'b0);
      check("rst_record", out_record, 134'd0);
      check("rst_level", level, 5'd0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_drops", drop_count, 16'd0);
      reset = 1'b1;

      // Single capture with the timestamp at 20.
      repeat (20) tick();
      send(2'd0, 32'h8000_0004, 32'd5, 4'hF, 32'h1234);
      check("single_valid", out_valid, 1'b1);
      check("single_record", out_record,
            {32'd20, 2'd0, 32'h8000_0004, 32'd5, 4'h0, 32'h0000_1234});
      check("single_level", level, 5'd1);
      drain(1);

      // Fill and overflow.
      for (int i = 0; i < 18; i++) send(2'd2, 32'h100 + i, 32'h2000 + 4 * i, 4'h1, i);
      check("fill_level", level, 5'd16);
      check("fill_overflow", overflow, 1'b1);
      check("fill_drops", drop_count, 16'd2);

      // Full with simultaneous pop: push accepted.
      out_ready = 1'b1;
      send(2'd0, 32'h300, 32'd7, 4'h0, 32'hAA55);
      check("fullpop_level", level, 5'd16);
      check("fullpop_drops", drop_count, 16'd2);
      repeat (16) tick();
      out_ready = 1'b0;
      check("drained_level", level, 5'd0);

      // Kind masking.
      send(2'd1, 32'h400, 32'h300, 4'hF, 32'hCAFE);
      r = out_record;
      check("csr_strb", r[35:32], 4'h0);
      check("csr_kind", r[101:100], 2'd1);
      drain(1);
      send(2'd2, 32'h404, 32'h8000_1000, 4'h3, 32'hBEEF);
      r = out_record;
      check("store_strb", r[35:32], 4'h3);
      check("store_addr", r[67:36], 32'h8000_1000);
      drain(1);
      send(2'd3, 32'h408, 32'h1, 4'hF, 32'h1);
      check("reserved_level", level, 5'd0);

      // Flush with level 7 and drop_count 3.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 19; i++) send(2'd0, 32'h500 + i, i, 4'h0, 32'h9000 + i);
      drain(9);
      check("preflush_level", level, 5'd7);
      check("preflush_drops", drop_count, 16'd3);
      flush = 1'b1;
      send(2'd0, 32'h600, 32'd1, 4'h0, 32'h1);
      flush = 1'b0;
      check("flush_level", level, 5'd0);
      check("flush_drops", drop_count, 16'd0);
      check("flush_overflow", overflow, 1'b0);
      tick();
      check("flush_discard", out_valid, 1'b0);

      // enable=0 ignores events.
      enable = 1'b0;
      in_valid = 1'b1;
      repeat (10) tick();
      in_valid = 1'b0;
      enable = 1'b1;
      check("disable_level", level, 5'd0);
      check("disable_drops", drop_count, 16'd0);

      // Async reset mid-drain.
      for (int i = 0; i < 9; i++) send(2'd1, 32'h700 + i, i, 4'h0, i);
      check("prereset_level", level, 5'd9);
      out_ready = 1'b1;
      reset = 1'b0;
      #1;
      check("async_valid", out_valid, 1'b0);
      check("async_level", level, 5'd0);
      repeat (3) tick();
      reset = 1'b1;
      send(2'd0, 32'h800, 32'd3, 4'h0, 32'h77);
      r = out_record;
      check("restart_valid", out_valid, 1'b1);
      check("restart_cycle", r[133:102], 32'd0);
      out_ready = 1'b0;
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
- Synthesizable retirement-trace capture stage, directly downstream of the execute stage.
- Consumes per-instruction commit events: register writes, CSR writes and stores.
- Timestamps each event, buffers it in a FIFO and drains it over a valid/ready stream to a trace sink (UART packer or bench monitor).
- Replaces hierarchical-probe logging with a real port-level interface that also works on FPGA.

Parameters:
- depth, 16, FIFO entries; power of two, minimum 2.
- cnt_width, 16, width of the saturating drop counter.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  capture enable; 0 ignores in_valid
- flush  in  1  synchronous clear of FIFO, drop counter and overflow flag
- in_valid  in  1  commit event present this cycle
- in_kind  in  2  0 = reg write, 1 = CSR write, 2 = store, 3 = reserved (never captured)
- in_pc  in  32  pc of committing instruction
- in_addr  in  32  reg index (zero-extended), CSR address (zero-extended) or store address
- in_strb  in  4  store byteenable; ignored and recorded as 0 for kinds 0/1
- in_data  in  32  wdata / cwdata / sdata
- out_valid  out  1  head record available
- out_ready  in  1  sink accepts head record
- out_record  out  134  {cycle[31:0], kind[1:0], pc, addr, strb, data}
- level  out  $clog2(depth)+1  current occupancy
- overflow  out  1  sticky: at least one event dropped
- drop_count  out  cnt_width  dropped events, saturating

Behaviour:
- Reset (reset=0, async): FIFO empty, out_valid=0, out_record=0, level=0, overflow=0, drop_count=0, cycle counter=0.
- Cycle counter:
  - 32-bit, increments every clock after reset, wraps 0xFFFFFFFF -> 0.
  - Not cleared by flush.
  - Value sampled in the cycle of capture is stored in the record.
- Capture condition: cap = enable & in_valid & (in_kind != 3).
- Pop: pop = out_valid & out_ready.
- Push: push = cap & (!full | pop).
  - When full, a simultaneous pop frees the slot the same cycle and the push is accepted.
- Drop: drop = cap & full & !pop.
  - overflow <= 1.
  - drop_count <= drop_count + 1, saturating at all-ones.
- FIFO is first-word-fall-through:
  - out_record = entry at read pointer; out_valid = !empty.
  - Event captured in cycle N appears on out_valid in cycle N+1 (empty FIFO).
- Simultaneous push and pop: level unchanged, both pointers advance.
- Pointers are log2(depth)+1 bits wide:
  - full = MSBs differ and low bits equal.
  - empty = pointers equal.
  - Wrap-around is natural.
- out_record must hold steady while out_valid=1 and out_ready=0.
- flush=1:
  - Next cycle: empty, level=0, overflow=0, drop_count=0.
  - Has priority over push/pop in the same cycle; that event is discarded and not counted.
- enable=0: no capture, no drops counted; draining continues.
- Reset asserted mid-stream: all state cleared immediately, regardless of out_ready.

Decomposition:
- In package configure:
  - trace_kind_t enum (TRACE_REG, TRACE_CSR, TRACE_STORE).
  - trace_rec_t packed struct (cycle, kind, pc, addr, strb, data).
  - Record width constant.
- Sub-module trace_fifo: generic FWFT FIFO parameterized by data width and depth, exposing push, pop, full, empty and level.
- trace_buffer adds the timestamp counter, capture/drop logic, strb masking and the counters.

Test Plan:
- Single capture: depth=16, out_ready=0, capture one event.
  - Stimulus: kind=0, pc=0x80000004, addr=5, data=0x1234 at cycle counter 20.
  - Response: next cycle out_valid=1, record {20, 0, 0x80000004, 5, 0, 0x1234}, level=1.
- Fill and overflow: out_ready=0, drive 18 consecutive valid events.
  - Response: level=16, overflow=1, drop_count=2.
  - Then out_ready=1 for 16 cycles: records exit in order, level returns to 0.
- Full with simultaneous pop: FIFO full, out_ready=1 and in_valid=1 in the same cycle.
  - Response: push accepted, level stays 16, drop_count unchanged.
- Kind masking:
  - kind=1 with in_strb=0xF: record strb=0.
  - kind=2 with in_strb=0x3, addr=0x80001000: record strb=0x3.
  - kind=3: not captured, level unchanged.
- Flush and enable:
  - Flush with level=7 and drop_count=3: next cycle level=0, drop_count=0, overflow=0, and the same-cycle event is discarded.
  - enable=0 with in_valid=1 for 10 cycles: level=0, drop_count=0.
- Async reset mid-drain: reset low for 3 cycles with level=9.
  - Response: out_valid=0 and level=0 immediately.
  - After release, cycle counter restarts from 0 in the first captured record.
